exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, the maximum cycles allowed between Run assertion and Done before a fault is raised.
REQ-002 Parameter CNT_W, default 16, the width of the instruction counter and the limit input.
REQ-003 Port Clock, in, 1: the single clock; all state updates on its rising edge.
REQ-004 Port Reset, in, 1: synchronous, active-high reset.
REQ-005 Port Step, in, 1: single-cycle pulse requesting execution of exactly one instruction.
REQ-006 Port Go, in, 1: single-cycle pulse starting continuous execution.
REQ-007 Port Halt, in, 1: level input; stops continuous execution at the next instruction boundary.
REQ-008 Port Limit, in, CNT_W: instruction-count limit for continuous mode; 0 means unlimited.
REQ-009 Port Done, in, 1: instruction-complete pulse from the multicycle processor.
REQ-010 Port BusWires, in, 16: the processor bus, sampled only for trace.
REQ-011 Port Run, out, 1: drives the processor Run input.
REQ-012 Port Busy, out, 1: high in states ISSUE and WAIT.
REQ-013 Port Fault, out, 1: high in state FAULT.
REQ-014 Port InstrCount, out, CNT_W: count of completed instructions.
REQ-015 Port TraceData, out, 16: the BusWires value captured at the most recent Done.
REQ-016 Port TraceValid, out, 1: one-cycle pulse when TraceData updates.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and FAULT.
REQ-018 IDLE: Step sets mode to single and Go sets mode to continuous; either one SHALL move to ISSUE on the next edge; if both arrive in the same cycle, Go wins.
REQ-019 ISSUE: Run=1; the watchdog counter SHALL clear; the FSM SHALL move to WAIT unconditionally.
REQ-020 WAIT: Run=1 and the watchdog increments each cycle.
REQ-021 WAIT, Done=1: InstrCount SHALL increment and wrap modulo 2^CNT_W, and Run SHALL drop in the same cycle Done is seen.
REQ-022 WAIT, Done=1, next state: IDLE if mode=single, Halt=1, or (Limit!=0 and the incremented count equals Limit); otherwise ISSUE.
REQ-023 WAIT, no Done: when the watchdog reaches TIMEOUT_CYCLES, the FSM SHALL move to FAULT with Run=0.
REQ-024 WAIT, Done arriving in the timeout cycle: Done wins, no fault.
REQ-025 FAULT: Run=0; Step and Go SHALL be ignored; only Reset exits FAULT.
REQ-026 Done seen outside WAIT SHALL be ignored, with no count change.
REQ-027 Step or Go arriving outside IDLE SHALL be dropped, not queued.
REQ-028 Run is a registered output; there SHALL be exactly one ISSUE cycle between consecutive instructions in continuous mode.

Reset
REQ-029 Reset SHALL force state=IDLE, mode=single, Run=0, Busy=0, Fault=0, InstrCount=0, watchdog=0, TraceData=0 and TraceValid=0 on the next edge, in any state including mid-instruction.
REQ-030 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-031 With macro EXEC_SEQUENCER_TRACE_EN defined: on each Done accepted in WAIT, TraceData SHALL latch BusWires and TraceValid SHALL pulse for one cycle.
REQ-032 Without EXEC_SEQUENCER_TRACE_EN: the ports remain, TraceData SHALL be held at 0, TraceValid SHALL be held at 0, and no trace register is synthesized.

Structure
REQ-033 A shared package exec_seq_pkg SHALL hold the state enumeration (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, FAULT=2'b11) and the mode encoding (single=0, continuous=1).
REQ-034 The watchdog SHALL be one sub-module, seq_watchdog, with clear, enable and expired ports, parameterized by TIMEOUT_CYCLES.

Verification
REQ-035 Reset, then a Step pulse, then Done 3 cycles after Run rises -> Run high for exactly those cycles, InstrCount=1, state IDLE, Fault=0.
REQ-036 Limit=4, Go pulse, Done returned 2 cycles after each Run -> exactly 4 Run bursts separated by one ISSUE cycle, InstrCount=4, then IDLE.
REQ-037 Limit=0, Go, Halt asserted during the 3rd instruction -> stop after the 3rd Done, InstrCount=3.
REQ-038 Step with Done never returned -> Fault=1 and Run=0 after TIMEOUT_CYCLES WAIT cycles; later Step/Go ignored; Reset clears everything.
REQ-039 TRACE_EN build, BusWires=16'h00A5 at Done -> TraceData=16'h00A5 and a 1-cycle TraceValid pulse; non-TRACE build -> both stay 0.
REQ-040 Reset asserted mid-WAIT and InstrCount wrap from 16'hFFFF -> all outputs reset next edge; wrap yields 16'h0000 with no fault.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg
// Shared types for the execution sequencer: the FSM state encoding and the
// execution-mode encoding. Imported by exec_sequencer.
// Ports: none (package).
package exec_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_CONT   = 1'b1
  } mode_t;

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog
// Cycle counter that bounds how long the sequencer waits for Done.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset, clears the count
//   clear   - synchronous clear (asserted while issuing an instruction)
//   enable  - count one cycle of waiting
//   expired - high during the TIMEOUT_CYCLES-th enabled cycle since clear
// Parameter TIMEOUT_CYCLES: number of waiting cycles allowed.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  // Count saturates at LAST so expired stays asserted if waiting continues.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The first waiting cycle sees count 0, so the TIMEOUT_CYCLES-th one sees LAST.
  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer
// Drives the Run input of a multicycle processor, either one instruction
// per Step pulse or continuously after a Go pulse, and watches each
// instruction with a timeout watchdog.
// Ports:
//   Clock, Reset      - clock and synchronous active-high reset
//   Step, Go          - single-cycle start requests (honoured only in IDLE)
//   Halt              - level; ends continuous execution at the next Done
//   Limit             - continuous-mode instruction limit, 0 = unlimited
//   Done              - instruction-complete pulse from the processor
//   BusWires          - processor bus, captured for trace only
//   Run               - registered Run to the processor
//   Busy, Fault       - status (ISSUE/WAIT, FAULT)
//   InstrCount        - completed instruction count (wraps)
//   TraceData/Valid   - bus value latched at the last accepted Done
// Build option: define EXEC_SEQUENCER_TRACE_EN to enable the trace capture;
// otherwise TraceData and TraceValid are tied to 0.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Step,
  input  logic             Go,
  input  logic             Halt,
  input  logic [CNT_W-1:0] Limit,
  input  logic             Done,
  input  logic [15:0]      BusWires,
  output logic             Run,
  output logic             Busy,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount,
  output logic [15:0]      TraceData,
  output logic             TraceValid
);

  state_t           state_reg, state_next;
  mode_t            mode_reg, mode_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             run_reg, run_next;
  logic             wd_clear, wd_enable, wd_expired;
  logic             accept;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (Clock),
    .reset  (Reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_SINGLE;
      count_reg <= '0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      count_reg <= count_next;
      run_reg   <= run_next;
    end
  end

  // run_next describes Run for the following cycle: it is raised while
  // issuing so it is high throughout WAIT, and cleared on the edge that
  // samples Done or the timeout. The ISSUE cycle between instructions
  // therefore shows up as a one-cycle low gap on Run.
  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    count_next = count_reg;
    run_next   = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Go) begin
          mode_next  = MODE_CONT;
          state_next = ISSUE;
        end else if (Step) begin
          mode_next  = MODE_SINGLE;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        wd_clear   = 1'b1;
        run_next   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        wd_enable = 1'b1;
        if (Done) begin
          // Done takes priority over a timeout in the same cycle.
          accept     = 1'b1;
          count_next = count_reg + 1'b1;
          if ((mode_reg == MODE_SINGLE) || Halt ||
              ((Limit != '0) && (count_next == Limit))) begin
            state_next = IDLE;
          end else begin
            state_next = ISSUE;
          end
        end else if (wd_expired) begin
          state_next = FAULT;
        end else begin
          run_next = 1'b1;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Run        = run_reg;
  assign Busy       = (state_reg == ISSUE) || (state_reg == WAIT);
  assign Fault      = (state_reg == FAULT);
  assign InstrCount = count_reg;

`ifdef EXEC_SEQUENCER_TRACE_EN
  logic [15:0] trace_data_reg;
  logic        trace_valid_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      trace_data_reg  <= '0;
      trace_valid_reg <= 1'b0;
    end else begin
      trace_valid_reg <= accept;
      if (accept) begin
        trace_data_reg <= BusWires;
      end
    end
  end

  assign TraceData  = trace_data_reg;
  assign TraceValid = trace_valid_reg;
`else
  // Trace disabled: bus and accept strobe are intentionally left unused.
  logic unused_trace;
  assign unused_trace = ^{BusWires, accept};
  assign TraceData    = '0;
  assign TraceValid   = 1'b0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Step = 1'b0, Go = 1'b0, Halt = 1'b0, Done = 1'b0;
  logic [15:0] Limit = '0;
  logic [15:0] BusWires = '0;

  logic        Run, Busy, Fault, TraceValid;
  logic [15:0] InstrCount, TraceData;

  // Narrow-counter instance used for the wrap check.
  logic        run_s, busy_s, fault_s, tvalid_s;
  logic [3:0]  count_s;
  logic [15:0] tdata_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  exec_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Step(Step), .Go(Go), .Halt(Halt),
    .Limit(Limit), .Done(Done), .BusWires(BusWires),
    .Run(Run), .Busy(Busy), .Fault(Fault), .InstrCount(InstrCount),
    .TraceData(TraceData), .TraceValid(TraceValid)
  );

  exec_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(4)) dut_small (
    .Clock(Clock), .Reset(Reset), .Step(Step), .Go(Go), .Halt(Halt),
    .Limit(Limit[3:0]), .Done(Done), .BusWires(BusWires),
    .Run(run_s), .Busy(busy_s), .Fault(fault_s), .InstrCount(count_s),
    .TraceData(tdata_s), .TraceValid(tvalid_s)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Wait for Run, keep Done low for n Run-high cycles with Done in the last,
  // then check Run dropped and whether another instruction is being issued.
  task automatic serve(input int n, input logic more);
    for (int i = 0; i < 20 && Run !== 1'b1; i++) tick();
    chk("run_rise", Run, 1);
    for (int k = 1; k < n; k++) begin
      tick();
      chk("run_hold", Run, 1);
    end
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("run_drop", Run, 0);
    chk("busy_after_done", Busy, more);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_run", Run, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_count", InstrCount, 0);
    chk("rst_tdata", TraceData, 0);
    chk("rst_tvalid", TraceValid, 0);

    // Done in IDLE is ignored
    Done = 1'b1; tick(); Done = 1'b0;
    chk("idle_done_count", InstrCount, 0);
    chk("idle_done_busy", Busy, 0);

    // Single step, Done in the 3rd Run-high cycle, Step during WAIT dropped
    Step = 1'b1; tick(); Step = 1'b0;
    chk("issue_busy", Busy, 1);
    chk("issue_run", Run, 0);
    tick(); chk("step_run_c1", Run, 1);
    Step = 1'b1; tick(); Step = 1'b0;
    chk("step_run_c2", Run, 1);
    tick(); chk("step_run_c3", Run, 1);
    Done = 1'b1; BusWires = 16'h00A5; tick(); Done = 1'b0; BusWires = 16'h0000;
    chk("step_run_drop", Run, 0);
    chk("step_idle", Busy, 0);
    chk("step_fault", Fault, 0);
    chk("step_count", InstrCount, 1);
`ifdef EXEC_SEQUENCER_TRACE_EN
    chk("trace_data", TraceData, 16'h00A5);
    chk("trace_valid", TraceValid, 1);
`else
    chk("trace_data_off", TraceData, 0);
    chk("trace_valid_off", TraceValid, 0);
`endif
    tick();
    chk("step_not_queued", Busy, 0);
    chk("trace_valid_pulse", TraceValid, 0);
`ifdef EXEC_SEQUENCER_TRACE_EN
    chk("trace_data_hold", TraceData, 16'h00A5);
`else
    chk("trace_data_hold_off", TraceData, 0);
`endif

    // Continuous, Limit=4, Done two cycles into each Run
    do_reset();
    Limit = 16'd4;
    Go = 1'b1; tick(); Go = 1'b0;
    serve(2, 1'b1);
    serve(2, 1'b1);
    serve(2, 1'b1);
    serve(2, 1'b0);
    chk("limit4_count", InstrCount, 4);
    tick();
    chk("limit4_idle_run", Run, 0);
    chk("limit4_idle_busy", Busy, 0);

    // Step and Go together: Go wins (continuous), Limit=2
    do_reset();
    Limit = 16'd2;
    Step = 1'b1; Go = 1'b1; tick(); Step = 1'b0; Go = 1'b0;
    serve(2, 1'b1);
    serve(2, 1'b0);
    chk("gowins_count", InstrCount, 2);

    // Unlimited, Halt during the 3rd instruction
    do_reset();
    Limit = 16'd0;
    Go = 1'b1; tick(); Go = 1'b0;
    serve(2, 1'b1);
    serve(2, 1'b1);
    Halt = 1'b1;
    serve(2, 1'b0);
    Halt = 1'b0;
    chk("halt_count", InstrCount, 3);

    // Timeout: no Done for 16 WAIT cycles -> FAULT
    do_reset();
    Step = 1'b1; tick(); Step = 1'b0;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    chk("to_last_wait_fault", Fault, 0);
    chk("to_last_wait_run", Run, 1);
    tick();
    chk("to_fault", Fault, 1);
    chk("to_fault_run", Run, 0);
    chk("to_fault_busy", Busy, 0);
    Step = 1'b1; tick(); Step = 1'b0;
    Go = 1'b1; tick(); Go = 1'b0;
    Done = 1'b1; tick(); Done = 1'b0;
    tick();
    chk("fault_sticky", Fault, 1);
    chk("fault_run", Run, 0);
    chk("fault_busy", Busy, 0);
    chk("fault_count", InstrCount, 0);
    Reset = 1'b1; Go = 1'b1; tick(); Reset = 1'b0; Go = 1'b0;
    chk("fault_rst_fault", Fault, 0);
    chk("fault_rst_busy", Busy, 0);
    chk("fault_rst_run", Run, 0);

    // Done in the timeout cycle wins
    Step = 1'b1; tick(); Step = 1'b0;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    Done = 1'b1; tick(); Done = 1'b0;
    chk("edge_done_fault", Fault, 0);
    chk("edge_done_count", InstrCount, 1);
    chk("edge_done_busy", Busy, 0);

    // Reset mid-WAIT with competing inputs
    do_reset();
    Limit = 16'd0;
    Go = 1'b1; tick(); Go = 1'b0;
    serve(2, 1'b1);
    tick();
    chk("midwait_run", Run, 1);
    Reset = 1'b1; Done = 1'b1; Go = 1'b1; BusWires = 16'h1234;
    tick();
    Reset = 1'b0; Done = 1'b0; Go = 1'b0; BusWires = 16'h0000;
    chk("midrst_run", Run, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_fault", Fault, 0);
    chk("midrst_count", InstrCount, 0);
    chk("midrst_tdata", TraceData, 0);
    chk("midrst_tvalid", TraceValid, 0);

    // Counter wrap on the 4-bit instance: 16 back-to-back instructions
    do_reset();
    Limit = 16'd0;
    Done = 1'b1;
    Go = 1'b1; tick(); Go = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("wrap_pre_small", count_s, 4'hF);
    chk("wrap_pre_wide", InstrCount, 15);
    Halt = 1'b1;
    tick();
    tick();
    Done = 1'b0; Halt = 1'b0;
    chk("wrap_small", count_s, 4'h0);
    chk("wrap_wide", InstrCount, 16);
    chk("wrap_fault", fault_s, 0);
    chk("wrap_busy", busy_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
